// File: rtl/shiftreg_in_pkg.sv
// Shared definitions for the serial receiver: byte and bit-counter widths
// and the receive state encoding.
package shiftreg_in_pkg;

   localparam int SHIFTREG_BYTE_W   = 8;
   localparam int SHIFTREG_BITCNT_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_e;

endpackage : shiftreg_in_pkg

// File: rtl/shiftreg_in_byte_fifo.sv
// Byte FIFO with show-ahead read port. Pointers carry one extra MSB so that
// full and empty are distinguishable. When empty, the output holds the last
// byte that was popped.
module byte_fifo
   import shiftreg_in_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic                       serial_clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [SHIFTREG_BYTE_W-1:0] data_i,
   output logic [SHIFTREG_BYTE_W-1:0] data_o,
   output logic [PTR_W-1:0]           count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       drop_o
);

   localparam int IDX_W = PTR_W - 1;

   logic [SHIFTREG_BYTE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [SHIFTREG_BYTE_W-1:0] hold_q, hold_d;
   logic                       pop_ok;
   logic                       wr_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;

   // A pop frees a slot on the same edge, so a push into a full FIFO
   // alongside a pop is accepted rather than dropped.
   assign pop_ok  = pop_i & ~empty_o;
   assign wr_ok   = push_i & (~full_o | pop_ok);
   assign drop_o  = push_i & full_o & ~pop_ok;

   assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q[IDX_W-1:0]];

   // Next pointer values and the byte remembered for the empty case.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, wr_ok};
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_ok};
      hold_d   = pop_ok ? data_o : hold_q;
   end

   // Pointer and hold registers.
   always_ff @(posedge serial_clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so ordering between statements does not matter.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hold_q   <= hold_d;
      end
   end

   // Storage writes.
   // NOTE: the storage array is deliberately not reset; an entry is only
   // ever observed after it has been written, and leaving it out of reset
   // keeps it mappable to plain RAM/flops without a reset tree.
   always_ff @(posedge serial_clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
      end
   end

endmodule : byte_fifo

// File: rtl/shiftreg_in.sv
// Serial-to-parallel receiver: samples serial_in MSB first while frame_en is
// high, assembles bytes and queues them in a byte FIFO for a parallel reader.
module shiftreg_in
   import shiftreg_in_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                       serial_clk,
   input  logic                       reset,
   input  logic                       serial_in,
   input  logic                       frame_en,
   input  logic                       rd_en,
   input  logic                       err_clear,
   output logic [SHIFTREG_BYTE_W-1:0] rd_data,
   output logic                       rd_valid,
   output logic [CNT_W-1:0]           count,
   output logic                       full,
   output logic                       overrun,
   output logic                       frame_err
);

   rx_state_e                    state_q, state_d;
   logic [SHIFTREG_BITCNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [SHIFTREG_BYTE_W-2:0]   sr_q, sr_d;
   logic                         overrun_q, overrun_d;
   logic                         frame_err_q, frame_err_d;
   logic                         push;
   logic                         frame_err_set;
   logic                         fifo_empty;
   logic                         fifo_drop;
   logic [SHIFTREG_BYTE_W-1:0]   push_byte;

   assign push_byte = {sr_q, serial_in};

   byte_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (CNT_W)
   ) u_fifo (
      .serial_clk (serial_clk),
      .reset      (reset),
      .push_i     (push),
      .pop_i      (rd_en),
      .data_i     (push_byte),
      .data_o     (rd_data),
      .count_o    (count),
      .full_o     (full),
      .empty_o    (fifo_empty),
      .drop_o     (fifo_drop)
   );

   assign rd_valid  = ~fifo_empty;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

   // Receive state machine: bit sampling, byte completion and frame ending.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d       = state_q;
      bitcnt_d      = bitcnt_q;
      sr_d          = sr_q;
      push          = 1'b0;
      frame_err_set = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            bitcnt_d = '0;
            if (frame_en) begin
               state_d  = ST_SHIFT;
               sr_d     = {sr_q[SHIFTREG_BYTE_W-3:0], serial_in};
               bitcnt_d = SHIFTREG_BITCNT_W'(1);
            end
         end
         ST_SHIFT: begin
            if (frame_en) begin
               sr_d     = {sr_q[SHIFTREG_BYTE_W-3:0], serial_in};
               bitcnt_d = bitcnt_q + SHIFTREG_BITCNT_W'(1);
               push     = (bitcnt_q == '1);
            end else begin
               state_d       = ST_IDLE;
               bitcnt_d      = '0;
               frame_err_set = (bitcnt_q != '0);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
         end
      endcase

      // A new error on the clearing edge wins over the clear.
      overrun_d   = fifo_drop     | (overrun_q   & ~err_clear);
      frame_err_d = frame_err_set | (frame_err_q & ~err_clear);
   end

   // State, shift register, bit counter and sticky flag registers.
   always_ff @(posedge serial_clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bitcnt_q    <= '0;
         sr_q        <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         sr_q        <= sr_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule : shiftreg_in

// File: tb/tb_shiftreg_in.sv
// Directed bench for shiftreg_in (DEPTH = 4): single byte, back-to-back
// stream, overrun, push+pop when full, frame error and asynchronous reset.
module tb_shiftreg_in;

   logic       serial_clk = 1'b0;
   logic       reset      = 1'b1;
   logic       serial_in  = 1'b1;
   logic       frame_en   = 1'b0;
   logic       rd_en      = 1'b0;
   logic       err_clear  = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [2:0] count;
   logic       full;
   logic       overrun;
   logic       frame_err;

   int n_compared = 0;
   int n_mismatch = 0;

   shiftreg_in #(
      .DEPTH (4),
      .CNT_W (3)
   ) dut (
      .serial_clk (serial_clk),
      .reset      (reset),
      .serial_in  (serial_in),
      .frame_en   (frame_en),
      .rd_en      (rd_en),
      .err_clear  (err_clear),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .count      (count),
      .full       (full),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 serial_clk = ~serial_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatch++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge; returns 1 time unit after it with inputs released.
   task automatic step();
      @(posedge serial_clk);
      #1;
      rd_en     = 1'b0;
      err_clear = 1'b0;
   endtask

   task automatic drive_bit(input logic b, input logic pop);
      serial_in = b;
      frame_en  = 1'b1;
      rd_en     = pop;
      step();
   endtask

   // Sends the top n bits of val MSB first; optional pop on the last bit.
   task automatic send_bits(input logic [7:0] val, input int n, input logic pop_last);
      for (int i = 7; i > 7 - n; i--) begin
         drive_bit(val[i], (i == 8 - n) ? pop_last : 1'b0);
      end
   endtask

   task automatic idle_edge(input logic pop, input logic clr);
      frame_en  = 1'b0;
      serial_in = 1'b1;
      rd_en     = pop;
      err_clear = clr;
      step();
   endtask

   task automatic read_expect(input string tag, input logic [7:0] exp);
      check(tag, rd_data, exp);
      idle_edge(1'b1, 1'b0);
   endtask

   initial begin
      // Reset state (asynchronous: visible before any edge)
      #1;
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_count", count, 3'd0);
      check("rst_full", full, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      step();
      reset = 1'b0;
      step();

      // Single byte A5
      send_bits(8'hA5, 7, 1'b0);
      check("single_not_yet_valid", rd_valid, 1'b0);
      drive_bit(1'b1, 1'b0);
      check("single_rd_data", rd_data, 8'hA5);
      check("single_rd_valid", rd_valid, 1'b1);
      check("single_count", count, 3'd1);
      idle_edge(1'b1, 1'b0);
      check("single_pop_count", count, 3'd0);
      check("single_pop_valid", rd_valid, 1'b0);
      check("single_clean_end", frame_err, 1'b0);
      check("single_hold_data", rd_data, 8'hA5);

      // Back-to-back stream of four bytes, frame held for 32 edges
      send_bits(8'h01, 8, 1'b0);
      send_bits(8'h80, 8, 1'b0);
      send_bits(8'hFF, 8, 1'b0);
      send_bits(8'h3C, 8, 1'b0);
      check("b2b_full", full, 1'b1);
      check("b2b_count", count, 3'd4);
      idle_edge(1'b0, 1'b0);
      check("b2b_end_frame_err", frame_err, 1'b0);
      read_expect("b2b_rd0", 8'h01);
      read_expect("b2b_rd1", 8'h80);
      read_expect("b2b_rd2", 8'hFF);
      read_expect("b2b_rd3", 8'h3C);
      check("b2b_drained_valid", rd_valid, 1'b0);
      check("b2b_drained_full", full, 1'b0);

      // Overrun: five bytes, no reads
      send_bits(8'h11, 8, 1'b0);
      send_bits(8'h22, 8, 1'b0);
      send_bits(8'h33, 8, 1'b0);
      send_bits(8'h44, 8, 1'b0);
      send_bits(8'h55, 7, 1'b0);
      check("ovr_before_drop", overrun, 1'b0);
      drive_bit(1'b1, 1'b0);
      check("ovr_set", overrun, 1'b1);
      check("ovr_count", count, 3'd4);
      idle_edge(1'b0, 1'b0);
      idle_edge(1'b0, 1'b1);
      check("ovr_cleared", overrun, 1'b0);
      read_expect("ovr_rd0", 8'h11);
      read_expect("ovr_rd1", 8'h22);
      read_expect("ovr_rd2", 8'h33);
      read_expect("ovr_rd3", 8'h44);
      check("ovr_drained", rd_valid, 1'b0);
      // rd_en on an empty FIFO is ignored
      idle_edge(1'b1, 1'b0);
      check("empty_pop_count", count, 3'd0);
      check("empty_pop_valid", rd_valid, 1'b0);

      // Push and pop on the same edge while full
      send_bits(8'h10, 8, 1'b0);
      send_bits(8'h20, 8, 1'b0);
      send_bits(8'h30, 8, 1'b0);
      send_bits(8'h40, 8, 1'b0);
      send_bits(8'h5A, 8, 1'b1);
      check("pp_no_overrun", overrun, 1'b0);
      check("pp_count", count, 3'd4);
      check("pp_full", full, 1'b1);
      idle_edge(1'b0, 1'b0);
      read_expect("pp_rd0", 8'h20);
      read_expect("pp_rd1", 8'h30);
      read_expect("pp_rd2", 8'h40);
      read_expect("pp_rd3", 8'h5A);

      // Frame error after 3 bits, then a clean byte from IDLE
      send_bits(8'hA0, 3, 1'b0);
      idle_edge(1'b0, 1'b0);
      check("ferr_set", frame_err, 1'b1);
      check("ferr_no_push", count, 3'd0);
      send_bits(8'h96, 8, 1'b0);
      idle_edge(1'b0, 1'b0);
      check("ferr_next_data", rd_data, 8'h96);
      check("ferr_next_count", count, 3'd1);
      check("ferr_sticky", frame_err, 1'b1);
      idle_edge(1'b1, 1'b1);
      check("ferr_cleared", frame_err, 1'b0);
      check("ferr_pop_count", count, 3'd0);
      // New error on the clearing edge wins
      send_bits(8'hC0, 2, 1'b0);
      idle_edge(1'b0, 1'b1);
      check("ferr_error_wins", frame_err, 1'b1);
      idle_edge(1'b0, 1'b1);
      check("ferr_cleared2", frame_err, 1'b0);

      // Asynchronous reset with 2 bytes buffered and 5 bits assembled
      send_bits(8'h12, 8, 1'b0);
      send_bits(8'h34, 8, 1'b0);
      send_bits(8'hF0, 5, 1'b0);
      check("arst_pre_count", count, 3'd2);
      #2;
      reset    = 1'b1;
      frame_en = 1'b0;
      #1;
      check("arst_valid", rd_valid, 1'b0);
      check("arst_count", count, 3'd0);
      check("arst_rd_data", rd_data, 8'h00);
      #1;
      reset = 1'b0;
      idle_edge(1'b0, 1'b0);
      check("arst_no_ferr", frame_err, 1'b0);
      check("arst_no_ovr", overrun, 1'b0);
      send_bits(8'hC3, 8, 1'b0);
      idle_edge(1'b0, 1'b0);
      check("arst_next_data", rd_data, 8'hC3);
      check("arst_next_count", count, 3'd1);
      check("arst_next_ferr", frame_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule : tb_shiftreg_in
